// File: rtl/echo_arbiter.sv
// echo_arbiter: two-port round-robin front end that sequences the echo shift unit
// (load, shift, capture) and returns the registered result with a shift-by-3 mismatch flag.
`default_nettype none

module echo_arbiter #(
    parameter int SETTLE = 2
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Req0,
    input  logic        Req1,
    input  logic [15:0] Data0,
    input  logic [15:0] Data1,
    output logic        Done0,
    output logic        Done1,
    output logic [15:0] Result,
    output logic        Error,
    output logic        Busy,
    output logic [15:0] Echo_data_in,
    output logic [7:0]  Echo_command,
    input  logic [15:0] Echo_data_out
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_LOAD    = 3'd1;
    localparam logic [2:0] S_EXEC    = 3'd2;
    localparam logic [2:0] S_CAPTURE = 3'd3;
    localparam logic [2:0] S_DONE    = 3'd4;

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

    localparam logic [7:0] CMD_IDLE  = 8'h02;
    localparam logic [7:0] CMD_LOAD  = 8'h00;
    localparam logic [7:0] CMD_SHIFT = 8'h01;

    logic [2:0]  state;
    logic [2:0]  state_next;
    logic [3:0]  hold_cnt;
    logic [15:0] operand;
    logic        grant_id;
    logic        last_grant;
    logic        mismatch;

    logic        any_req;
    logic        pick;
    logic        phase_end;
    logic        holding;
    logic [15:0] expected;

    // Tie goes to the requester that did not win last time.
    always_comb begin
        any_req = Req0 | Req1;
        if (Req0 && Req1) begin
            pick = ~last_grant;
        end else begin
            pick = Req1;
        end
        phase_end = (hold_cnt == SETTLE_LAST);
        holding   = (state == S_LOAD) || (state == S_EXEC);
        expected  = {operand[12:0], 3'b000};
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:    if (any_req)   state_next = S_LOAD;
            S_LOAD:    if (phase_end) state_next = S_EXEC;
            S_EXEC:    if (phase_end) state_next = S_CAPTURE;
            S_CAPTURE: state_next = S_DONE;
            S_DONE:    state_next = S_IDLE;
            default:   state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            hold_cnt   <= 4'd0;
            operand    <= 16'h0000;
            grant_id   <= 1'b0;
            last_grant <= 1'b1;
            Result     <= 16'h0000;
            mismatch   <= 1'b0;
        end else begin
            if (holding && !phase_end) begin
                hold_cnt <= hold_cnt + 4'd1;
            end else begin
                hold_cnt <= 4'd0;
            end

            if ((state == S_IDLE) && any_req) begin
                operand    <= pick ? Data1 : Data0;
                grant_id   <= pick;
                last_grant <= pick;
            end

            if (state == S_CAPTURE) begin
                Result   <= Echo_data_out;
                mismatch <= (Echo_data_out != expected);
            end
        end
    end

    always_comb begin
        Echo_command = CMD_IDLE;
        Echo_data_in = 16'h0000;
        Busy         = 1'b1;
        Done0        = 1'b0;
        Done1        = 1'b0;
        Error        = 1'b0;
        case (state)
            S_IDLE: begin
                Busy = 1'b0;
            end
            S_LOAD: begin
                Echo_command = CMD_LOAD;
                Echo_data_in = operand;
            end
            S_EXEC, S_CAPTURE: begin
                Echo_command = CMD_SHIFT;
                Echo_data_in = operand;
            end
            S_DONE: begin
                Done0 = ~grant_id;
                Done1 = grant_id;
                Error = mismatch;
            end
            default: begin
                Busy = 1'b0;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_echo_arbiter.sv
// tb_echo_arbiter: directed stimulus with a cycle-offset reference model and a stand-in echo unit.
`default_nettype none

module tb_echo_arbiter;

    localparam int S = 2;

    logic        clk = 1'b0;
    logic        Reset = 1'b1;
    logic        Req0 = 1'b0, Req1 = 1'b0;
    logic [15:0] Data0 = 16'h0, Data1 = 16'h0;
    logic        Done0, Done1, Error, Busy;
    logic [15:0] Result, Echo_data_in, Echo_data_out;
    logic [7:0]  Echo_command;

    logic        b_req0 = 1'b0;
    logic [15:0] b_data0 = 16'h0;
    logic        b_done0, b_done1, b_error, b_busy;
    logic [15:0] b_result, b_din, b_dout;
    logic [7:0]  b_cmd;

    logic        corrupt = 1'b0;
    logic [15:0] held = 16'h0, b_held = 16'h0;

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    echo_arbiter #(.SETTLE(S)) dut (
        .Clk(clk), .Reset(Reset), .Req0(Req0), .Req1(Req1),
        .Data0(Data0), .Data1(Data1), .Done0(Done0), .Done1(Done1),
        .Result(Result), .Error(Error), .Busy(Busy),
        .Echo_data_in(Echo_data_in), .Echo_command(Echo_command),
        .Echo_data_out(Echo_data_out)
    );

    echo_arbiter #(.SETTLE(1)) dut_b (
        .Clk(clk), .Reset(Reset), .Req0(b_req0), .Req1(1'b0),
        .Data0(b_data0), .Data1(16'h0000), .Done0(b_done0), .Done1(b_done1),
        .Result(b_result), .Error(b_error), .Busy(b_busy),
        .Echo_data_in(b_din), .Echo_command(b_cmd),
        .Echo_data_out(b_dout)
    );

    // Stand-in echo unit: latch operand on load, drive operand<<3 while shifting.
    always @(posedge clk) if (Echo_command == 8'h00) held <= Echo_data_in;
    always @(posedge clk) if (b_cmd == 8'h00) b_held <= b_din;
    assign Echo_data_out = corrupt ? 16'h1234 :
                           (Echo_command[0] ? {held[12:0], 3'b000} : 16'h0000);
    assign b_dout = b_cmd[0] ? {b_held[12:0], 3'b000} : 16'h0000;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: timed out waiting for DUT (t=%0t)", name, $time);
    endtask

    // Reference model: outputs follow from the cycle offset k since the grant.
    logic        m_valid = 1'b0, m_active = 1'b0, m_who = 1'b0, m_ptr = 1'b1, m_err = 1'b0;
    logic [15:0] m_op = 16'h0, m_exp = 16'h0, m_res = 16'h0;
    int          m_g = 0;

    always @(negedge clk) begin
        int k;
        logic [7:0]  e_cmd;
        logic [15:0] e_din;
        logic        e_done, idle_now;
        idle_now = !m_active;
        k = cyc - m_g;
        e_cmd = 8'h02;
        e_din = 16'h0000;
        e_done = 1'b0;
        if (m_active) begin
            if (k >= 1 && k <= S) e_cmd = 8'h00;
            else if (k > S && k <= 2 * S + 1) e_cmd = 8'h01;
            if (k <= 2 * S + 1) e_din = m_op;
            if (k == 2 * S + 2) begin
                e_done = 1'b1;
                m_res = m_exp;
            end
        end
        if (m_valid) begin
            check("cmd", 16'(Echo_command), 16'(e_cmd));
            check("data_in", Echo_data_in, e_din);
            check("busy", 16'(Busy), 16'(m_active));
            check("done0", 16'(Done0), 16'(e_done && !m_who));
            check("done1", 16'(Done1), 16'(e_done && m_who));
            check("error", 16'(Error), 16'(e_done && m_err));
            check("result", Result, m_res);
        end
        if (e_done) m_active = 1'b0;
        if (Reset) begin
            m_active = 1'b0;
            m_res = 16'h0000;
            m_ptr = 1'b1;
            m_valid = 1'b1;
        end else if (idle_now && (Req0 || Req1)) begin
            m_who = (Req0 && Req1) ? !m_ptr : Req1;
            m_ptr = m_who;
            m_op = m_who ? Data1 : Data0;
            m_exp = corrupt ? 16'h1234 : {m_op[12:0], 3'b000};
            m_err = (m_exp != {m_op[12:0], 3'b000});
            m_g = cyc;
            m_active = 1'b1;
        end
    end

    logic [7:0] cmd_log [0:39];

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic run_until_done(output int lat, output logic d0, output logic d1,
                                  output logic err, output logic [15:0] res);
        lat = -1;
        d0 = 1'b0; d1 = 1'b0; err = 1'b0; res = 16'h0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            cmd_log[i] = Echo_command;
            if (Done0 || Done1) begin
                lat = i; d0 = Done0; d1 = Done1; err = Error; res = Result;
                break;
            end
        end
        if (lat < 0) timeout("done_wait");
    endtask

    initial begin
        int lat, hits;
        logic d0, d1, err;
        logic [15:0] res;
        logic [7:0] exp_seq [0:6];
        logic [15:0] exp_res [0:3];
        logic exp_who [0:3];
        exp_seq = '{8'h02, 8'h00, 8'h00, 8'h01, 8'h01, 8'h01, 8'h02};
        exp_res = '{16'h0008, 16'h0010, 16'h0008, 16'h0010};
        exp_who = '{1'b0, 1'b1, 1'b0, 1'b1};

        repeat (3) tick();
        Reset = 1'b0;
        @(negedge clk);
        check("rst_cmd", 16'(Echo_command), 16'h0002);
        check("rst_result", Result, 16'h0000);
        check("rst_busy", 16'(Busy), 16'h0000);

        // Single request from port 0
        tick(); Req0 = 1'b1; Data0 = 16'h0005;
        run_until_done(lat, d0, d1, err, res);
        check("t1_latency", 16'(lat), 16'd6);
        for (int i = 0; i < 7; i++) check("t1_cmd_seq", 16'(cmd_log[i]), 16'(exp_seq[i]));
        check("t1_done0", 16'(d0), 16'h1);
        check("t1_result", res, 16'h0028);
        check("t1_error", 16'(err), 16'h0);
        tick(); Req0 = 1'b0;

        // Truncation of the top operand bits
        tick(); Req1 = 1'b1; Data1 = 16'hFFFF;
        run_until_done(lat, d0, d1, err, res);
        check("t2_done1", 16'(d1), 16'h1);
        check("t2_done0", 16'(d0), 16'h0);
        check("t2_result", res, 16'hFFF8);
        check("t2_error", 16'(err), 16'h0);
        tick(); Req1 = 1'b0;

        // Both requesters held: grants alternate
        tick(); Req0 = 1'b1; Req1 = 1'b1; Data0 = 16'h0001; Data1 = 16'h0002;
        for (int j = 0; j < 4; j++) begin
            run_until_done(lat, d0, d1, err, res);
            check("t3_latency", 16'(lat), 16'd6);
            check("t3_who", 16'(d1), 16'(exp_who[j]));
            check("t3_onehot", 16'(d0 ^ d1), 16'h1);
            check("t3_result", res, exp_res[j]);
        end
        tick(); Req0 = 1'b0; Req1 = 1'b0;

        // Corrupted echo output raises Error with Done
        tick(); corrupt = 1'b1; Req0 = 1'b1; Data0 = 16'h0003;
        run_until_done(lat, d0, d1, err, res);
        check("t4_done0", 16'(d0), 16'h1);
        check("t4_error", 16'(err), 16'h1);
        check("t4_result", res, 16'h1234);
        tick(); Req0 = 1'b0; corrupt = 1'b0;

        // Reset during EXEC aborts the job silently
        tick(); Req0 = 1'b1; Data0 = 16'h0007;
        hits = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (Echo_command == 8'h01) begin
                hits = 1;
                break;
            end
        end
        if (hits == 0) timeout("t5_exec_wait");
        tick(); Reset = 1'b1; Req0 = 1'b0;
        tick(); Reset = 1'b0;
        @(negedge clk);
        check("t5_cmd", 16'(Echo_command), 16'h0002);
        check("t5_result", Result, 16'h0000);
        check("t5_busy", 16'(Busy), 16'h0000);
        hits = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (Done0 || Done1 || Error) hits++;
        end
        check("t5_no_done", 16'(hits), 16'd0);

        // SETTLE=1 instance
        tick(); b_req0 = 1'b1; b_data0 = 16'h0010;
        lat = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (b_done0 || b_done1) begin
                lat = i; d0 = b_done0; d1 = b_done1; err = b_error; res = b_result;
                break;
            end
        end
        if (lat < 0) timeout("t6_done_wait");
        else begin
            check("t6_latency", 16'(lat), 16'd4);
            check("t6_done0", 16'(d0), 16'h1);
            check("t6_done1", 16'(d1), 16'h0);
            check("t6_result", res, 16'h0080);
            check("t6_error", 16'(err), 16'h0);
        end
        tick(); b_req0 = 1'b0;

        repeat (4) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
